// File: rtl/cla_addsub_pipe_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    // Operation encoding on in_op
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    // Width of one first-level lookahead group
    localparam int GROUP_W = 4;

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle. The master side is the upstream operand
// source together with the downstream result sink; the slave side is the adder.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );
endinterface

// File: rtl/cla_addsub_pipe_cla.sv
// Carry-lookahead building blocks: a 4-bit group and a half-width adder made
// of groups joined by a second-level lookahead (no ripple between groups).
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               p,
    output logic               g
);
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Internal bit carries, each expanded directly from cin and the bit P/G
    always_comb begin
        w_c[0] = cin;
        w_c[1] = w_g[0] | (w_p[0] & cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
    end

    assign sum = w_p ^ w_c;
    assign p   = &w_p;
    assign g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module cla_half
    import cla_pkg::*;
#(
    parameter int HW = 4
)(
    input  logic [HW-1:0] a,
    input  logic [HW-1:0] b,
    input  logic          cin,
    output logic [HW-1:0] sum,
    output logic          cout
);
    localparam int NG = HW / GROUP_W;

    logic [NG-1:0] w_gp;
    logic [NG-1:0] w_gg;
    logic [NG:0]   w_gc;
    logic          v_c;
    logic          v_t;

    // Second-level lookahead: every group carry is a flat sum of products of
    // group G/P terms and cin, so no group waits on its neighbour's carry.
    always_comb begin
        w_gc = '0;
        v_c  = 1'b0;
        v_t  = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            v_c = cin;
            for (int m = 0; m < k; m++) v_c = v_c & w_gp[m];
            for (int j = 0; j < k; j++) begin
                v_t = w_gg[j];
                for (int m = j + 1; m < k; m++) v_t = v_t & w_gp[m];
                v_c = v_c | v_t;
            end
            w_gc[k] = v_c;
        end
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group4 u_grp (
            .a   (a[gi*GROUP_W +: GROUP_W]),
            .b   (b[gi*GROUP_W +: GROUP_W]),
            .cin (w_gc[gi]),
            .sum (sum[gi*GROUP_W +: GROUP_W]),
            .p   (w_gp[gi]),
            .g   (w_gg[gi])
        );
    end

    assign cout = w_gc[NG];
endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead add/sub with flags. Stage 0 adds the low
// half and captures the half-carry; stage 1 adds the high half and registers
// the result and flags. Simple valid/ready skid-free pipeline.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    cla_addsub_pipe_if.slave bus
);
    localparam int HW = WIDTH / 2;

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_chk
        $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of 8");
    end

    logic             w_s0_en;
    logic             w_s1_en;
    logic [WIDTH-1:0] w_b_prep;
    logic             w_c0;
    logic [HW-1:0]    w_sum_lo;
    logic             w_hc;
    logic [HW-1:0]    w_sum_hi;
    logic             w_cout;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_sum_full;

    logic             r_s0_vld;
    logic [HW-1:0]    r_sum_lo;
    logic             r_hc;
    logic [HW-1:0]    r_a_hi;
    logic [HW-1:0]    r_b_hi;

    logic             r_out_vld;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    // Each stage advances when its downstream slot is empty or draining
    assign w_s1_en = !r_out_vld || bus.out_ready;
    assign w_s0_en = !r_s0_vld  || w_s1_en;

    // Operand prep: subtraction is A + ~B + c0
    always_comb begin
        w_b_prep = bus.in_b;
        w_c0     = 1'b0;
        case (bus.in_op)
            OP_ADD: begin w_b_prep = bus.in_b;  w_c0 = 1'b0;       end
            OP_ADC: begin w_b_prep = bus.in_b;  w_c0 = bus.in_cin; end
            OP_SUB: begin w_b_prep = ~bus.in_b; w_c0 = 1'b1;       end
            OP_SBC: begin w_b_prep = ~bus.in_b; w_c0 = bus.in_cin; end
            default: ;
        endcase
    end

    cla_half #(.HW(HW)) u_lo (
        .a    (bus.in_a[HW-1:0]),
        .b    (w_b_prep[HW-1:0]),
        .cin  (w_c0),
        .sum  (w_sum_lo),
        .cout (w_hc)
    );

    // Stage 0: low-half sum, half-carry and the upper operand halves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_vld <= 1'b0;
            r_sum_lo <= '0;
            r_hc     <= 1'b0;
            r_a_hi   <= '0;
            r_b_hi   <= '0;
        end else if (w_s0_en) begin
            r_s0_vld <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum_lo <= w_sum_lo;
                r_hc     <= w_hc;
                r_a_hi   <= bus.in_a[WIDTH-1:HW];
                r_b_hi   <= w_b_prep[WIDTH-1:HW];
            end
        end
    end

    cla_half #(.HW(HW)) u_hi (
        .a    (r_a_hi),
        .b    (r_b_hi),
        .cin  (r_hc),
        .sum  (w_sum_hi),
        .cout (w_cout)
    );

    // Carry into the MSB recovered from the MSB sum bit and its operands
    assign w_c_msb    = w_sum_hi[HW-1] ^ r_a_hi[HW-1] ^ r_b_hi[HW-1];
    assign w_sum_full = {w_sum_hi, r_sum_lo};

    // Stage 1: output register holds result and flags stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
        end else if (w_s1_en) begin
            r_out_vld <= r_s0_vld;
            if (r_s0_vld) begin
                r_sum  <= w_sum_full;
                r_cout <= w_cout;
                r_ovf  <= w_c_msb ^ w_cout;
                r_zero <= (w_sum_full == '0);
                r_neg  <= w_sum_full[WIDTH-1];
            end
        end
    end

    assign bus.in_ready  = w_s0_en;
    assign bus.out_valid = r_out_vld;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_zero  = r_zero;
    assign bus.out_neg   = r_neg;
endmodule
